// File: rtl/fetch_queue_pkg.sv
// Shared constants and helpers for the instruction fetch queue.
package fetch_queue_pkg;

  localparam int unsigned INSTRUCTION_WIDTH = 32;
  localparam int unsigned PC_WIDTH          = 32;
  localparam logic [31:0] NOP_INSTRUCTION   = 32'h0000_0000;

  // Per-cycle queue operation, encoded as {pop, push}
  typedef enum logic [1:0] {
    Q_HOLD     = 2'b00,
    Q_PUSH     = 2'b01,
    Q_POP      = 2'b10,
    Q_PUSH_POP = 2'b11
  } q_op_e;

  function automatic q_op_e q_op(input logic push, input logic pop);
    return q_op_e'({pop, push});
  endfunction

endpackage

// File: rtl/fetch_queue_storage.sv
// Entry storage for fetch_queue: DEPTH x WIDTH register array with one
// synchronous write port and one combinational read port. Not reset.
module fetch_queue_storage #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port: one entry per cycle when enabled
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Combinational read of the addressed entry
  always_comb begin
    rd_data = mem[rd_addr];
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue between IF and ID. Buffers DEPTH entries,
// empties on flush, presents a zero NOP bubble when no entry is valid.
// Optional feature: define FETCH_QUEUE_BYPASS_EN for a 0-cycle
// empty-queue pass-through from in_* to out_*.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned INST_WIDTH = INSTRUCTION_WIDTH,
  parameter int unsigned PC_WIDTH   = fetch_queue_pkg::PC_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [INST_WIDTH-1:0]    in_instruction,
  input  logic [PC_WIDTH-1:0]      in_next_pc,
  input  logic                     flush,
  input  logic                     stall_pipeline,
  output logic                     out_valid,
  output logic [INST_WIDTH-1:0]    out_instruction,
  output logic [PC_WIDTH-1:0]      out_next_pc,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = INST_WIDTH + PC_WIDTH;

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [EW-1:0] head_data;
  logic          bypass;
  logic          pop;
  logic          push;
  logic          wr_en;
  logic          rd_adv;
  q_op_e         op;

  fetch_queue_storage #(
    .DEPTH (DEPTH),
    .WIDTH (EW),
    .AW    (AW)
  ) u_storage (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data ({in_instruction, in_next_pc}),
    .rd_addr (rd_ptr),
    .rd_data (head_data)
  );

  // Status flags derived from the registered occupancy
  always_comb begin
    full     = (count == CW'(DEPTH));
    empty    = (count == '0);
    in_ready = !full;
  end

  // Head/bypass selection, NOP zeroing and push/pop qualification
  always_comb begin
    bypass = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
    bypass = empty && in_valid;
`endif
    out_valid       = !flush && (!empty || bypass);
    out_instruction = INST_WIDTH'(NOP_INSTRUCTION);
    out_next_pc     = '0;
    if (out_valid) begin
      if (!empty) begin
        out_instruction = head_data[EW-1:PC_WIDTH];
        out_next_pc     = head_data[PC_WIDTH-1:0];
      end else begin
        out_instruction = in_instruction;
        out_next_pc     = in_next_pc;
      end
    end
    pop  = out_valid && !stall_pipeline;
    push = in_valid && in_ready && !flush;
    // A bypassed entry consumed in the same cycle never touches storage,
    // so neither the write nor the read pointer moves.
    wr_en  = push && !(bypass && pop);
    rd_adv = pop && !bypass;
    op     = q_op(wr_en, rd_adv);
  end

  // Pointer and occupancy registers; flush clears everything at the edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      unique case (op)
        Q_PUSH: begin
          wr_ptr <= wr_ptr + AW'(1);
          count  <= count + CW'(1);
        end
        Q_POP: begin
          rd_ptr <= rd_ptr + AW'(1);
          count  <= count - CW'(1);
        end
        Q_PUSH_POP: begin
          wr_ptr <= wr_ptr + AW'(1);
          rd_ptr <= rd_ptr + AW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (DEPTH = 4).
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instruction;
  logic [31:0] in_next_pc;
  logic        flush;
  logic        stall_pipeline;
  logic        out_valid;
  logic [31:0] out_instruction;
  logic [31:0] out_next_pc;
  logic [2:0]  count;
  logic        full;
  logic        empty;

  int checks   = 0;
  int failures = 0;

  fetch_queue #(
    .DEPTH      (4),
    .INST_WIDTH (32),
    .PC_WIDTH   (32)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_instruction  (in_instruction),
    .in_next_pc      (in_next_pc),
    .flush           (flush),
    .stall_pipeline  (stall_pipeline),
    .out_valid       (out_valid),
    .out_instruction (out_instruction),
    .out_next_pc     (out_next_pc),
    .count           (count),
    .full            (full),
    .empty           (empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge; registered state is sampled 1 time unit later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_instruction = '0; in_next_pc = '0;
    flush = 1'b0; stall_pipeline = 1'b0;

    // Reset then idle
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_instr", out_instruction, 0);
    check("rst_out_pc", out_next_pc, 0);
    check("rst_count", count, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    tick(); tick();
    rst = 1'b0;
    tick();
    check("idle_out_valid", out_valid, 0);
    check("idle_count", count, 0);

    // Fill under stall
    stall_pipeline = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_instruction = 32'h00A1_0000 + 32'(i);
      in_next_pc = 32'h100 + 32'(i);
      #1;
      if (i == 0) begin
`ifdef FETCH_QUEUE_BYPASS_EN
        check("fill0_bypass_valid", out_valid, 1);
        check("fill0_bypass_instr", out_instruction, 32'h00A1_0000);
`else
        check("fill0_out_valid", out_valid, 0);
        check("fill0_out_instr", out_instruction, 0);
`endif
      end
      tick();
      check("fill_count", count, 64'(i + 1));
      check("fill_head_held", out_instruction, 32'h00A1_0000);
      check("fill_head_pc", out_next_pc, 32'h100);
    end
    check("full_flag", full, 1);
    check("full_in_ready", in_ready, 0);
    check("full_empty", empty, 0);
    in_instruction = 32'h00A1_0004;
    tick();
    check("reject5_count", count, 4);
    check("reject5_head", out_instruction, 32'h00A1_0000);

    // Drain order
    in_valid = 1'b0;
    stall_pipeline = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("drain_valid", out_valid, 1);
      check("drain_instr", out_instruction, 32'h00A1_0000 + 32'(i));
      check("drain_pc", out_next_pc, 32'h100 + 32'(i));
      tick();
    end
    check("drain_done_valid", out_valid, 0);
    check("drain_done_empty", empty, 1);
    check("drain_done_instr", out_instruction, 0);

    // Preload two entries under stall, then simultaneous push/pop across wrap
    stall_pipeline = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_instruction = 32'h00B0_0000 + 32'(i);
      in_next_pc = 32'h200 + 32'(i);
      tick();
    end
    check("pp_pre_count", count, 2);
    stall_pipeline = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_instruction = 32'h00B0_0002 + 32'(k);
      in_next_pc = 32'h202 + 32'(k);
      #1;
      check("pp_instr", out_instruction, 32'h00B0_0000 + 32'(k));
      tick();
      check("pp_count", count, 2);
    end
    // Remaining B4, B5 then add C0 under stall -> count 3
    stall_pipeline = 1'b1;
    in_instruction = 32'h00C0_0000;
    in_next_pc = 32'h300;
    tick();
    check("pre_flush_count", count, 3);
    check("pre_flush_head", out_instruction, 32'h00B0_0004);

    // Flush with concurrent push
    flush = 1'b1;
    in_valid = 1'b1;
    in_instruction = 32'hDEAD_BEEF;
    in_next_pc = 32'h3FF;
    #1;
    check("flush_out_valid", out_valid, 0);
    check("flush_out_instr", out_instruction, 0);
    check("flush_out_pc", out_next_pc, 0);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    stall_pipeline = 1'b0;
    check("post_flush_count", count, 0);
    check("post_flush_empty", empty, 1);
    #1;
    check("post_flush_valid", out_valid, 0);
    tick();
    check("post_flush_valid2", out_valid, 0);
    check("post_flush_instr2", out_instruction, 0);

    // Push into an empty queue with no stall
    in_valid = 1'b1;
    in_instruction = 32'h1234_5678;
    in_next_pc = 32'h55;
    #1;
`ifdef FETCH_QUEUE_BYPASS_EN
    check("byp_same_valid", out_valid, 1);
    check("byp_same_instr", out_instruction, 32'h1234_5678);
    check("byp_same_pc", out_next_pc, 32'h55);
    tick();
    in_valid = 1'b0;
    check("byp_count", count, 0);
    #1;
    check("byp_after_valid", out_valid, 0);
`else
    check("nobyp_same_valid", out_valid, 0);
    check("nobyp_same_instr", out_instruction, 0);
    tick();
    in_valid = 1'b0;
    check("nobyp_count", count, 1);
    #1;
    check("nobyp_next_valid", out_valid, 1);
    check("nobyp_next_instr", out_instruction, 32'h1234_5678);
    check("nobyp_next_pc", out_next_pc, 32'h55);
    tick();
    check("nobyp_popped_count", count, 0);
`endif

    // Asynchronous reset mid-operation
    stall_pipeline = 1'b1;
    in_valid = 1'b1;
    in_instruction = 32'h00E0_0000;
    tick();
    in_valid = 1'b0;
    check("arst_pre_count", count, 1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_count", count, 0);
    check("arst_valid", out_valid, 0);
    check("arst_in_ready", in_ready, 1);
    #1;
    rst = 1'b0;
    tick();
    check("arst_after_empty", empty, 1);
    check("arst_after_valid", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
